// File: rtl/tlb_pipe.sv
// Pipelined fully associative LoongArch TLB: two registered search ports, a registered read port,
// TLBWR/TLBFILL writes and INVTLB. Optional multi-hit flags under `TLB_MULTIHIT_EN.
module tlb_pipe #(
  parameter int unsigned TLBNUM = 16,
  localparam int unsigned IW = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s0_req,
  input  logic [18:0]   s0_vppn,
  input  logic          s0_va_bit12,
  input  logic [9:0]    s0_asid,
  output logic          s0_rvalid,
  output logic          s0_found,
  output logic [IW-1:0] s0_index,
  output logic [19:0]   s0_ppn,
  output logic [5:0]    s0_ps,
  output logic [1:0]    s0_plv,
  output logic [1:0]    s0_mat,
  output logic          s0_d,
  output logic          s0_v,
`ifdef TLB_MULTIHIT_EN
  output logic          s0_multihit,
  output logic          s1_multihit,
`endif
  input  logic          s1_req,
  input  logic [18:0]   s1_vppn,
  input  logic          s1_va_bit12,
  input  logic [9:0]    s1_asid,
  output logic          s1_rvalid,
  output logic          s1_found,
  output logic [IW-1:0] s1_index,
  output logic [19:0]   s1_ppn,
  output logic [5:0]    s1_ps,
  output logic [1:0]    s1_plv,
  output logic [1:0]    s1_mat,
  output logic          s1_d,
  output logic          s1_v,
  input  logic          we,
  input  logic          w_fill,
  input  logic [IW-1:0] w_index,
  input  logic          w_e,
  input  logic [18:0]   w_vppn,
  input  logic [5:0]    w_ps,
  input  logic [9:0]    w_asid,
  input  logic          w_g,
  input  logic [19:0]   w_ppn0,
  input  logic [1:0]    w_plv0,
  input  logic [1:0]    w_mat0,
  input  logic          w_d0,
  input  logic          w_v0,
  input  logic [19:0]   w_ppn1,
  input  logic [1:0]    w_plv1,
  input  logic [1:0]    w_mat1,
  input  logic          w_d1,
  input  logic          w_v1,
  output logic [IW-1:0] fill_index,
  input  logic          r_req,
  input  logic [IW-1:0] r_index,
  output logic          r_rvalid,
  output logic          r_e,
  output logic [18:0]   r_vppn,
  output logic [5:0]    r_ps,
  output logic [9:0]    r_asid,
  output logic          r_g,
  output logic [19:0]   r_ppn0,
  output logic [1:0]    r_plv0,
  output logic [1:0]    r_mat0,
  output logic          r_d0,
  output logic          r_v0,
  output logic [19:0]   r_ppn1,
  output logic [1:0]    r_plv1,
  output logic [1:0]    r_mat1,
  output logic          r_d1,
  output logic          r_v1,
  input  logic          inv_valid,
  input  logic [4:0]    inv_op,
  input  logic [9:0]    inv_asid,
  input  logic [18:0]   inv_vppn,
  output logic          inv_ack,
  output logic          inv_err
);

  function automatic logic va_match(input logic [18:0] ent, input logic ps4m,
                                    input logic [18:0] va);
    return (ent[18:9] == va[18:9]) && (ps4m || (ent[8:0] == va[8:0]));
  endfunction

  // Entry array; only E is reset.
  logic [TLBNUM-1:0] e_q, ps4mb_q, g_q;
  logic [18:0] vppn_q [TLBNUM];
  logic [9:0]  asid_q [TLBNUM];
  logic [19:0] ppn_q  [2][TLBNUM];
  logic [1:0]  plv_q  [2][TLBNUM];
  logic [1:0]  mat_q  [2][TLBNUM];
  logic [1:0]  d_q    [TLBNUM];
  logic [1:0]  v_q    [TLBNUM];

  logic [IW-1:0] fill_q;
  logic [IW-1:0] wr_idx;
  logic          inv_acc;
  logic [TLBNUM-1:0] inv_sel;

  assign wr_idx  = w_fill ? fill_q : w_index;
  assign inv_acc = inv_valid && !we;

  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      logic vam, asm;
      vam = va_match(vppn_q[i], ps4mb_q[i], inv_vppn);
      asm = asid_q[i] == inv_asid;
      case (inv_op)
        5'd0, 5'd1: inv_sel[i] = 1'b1;
        5'd2:       inv_sel[i] = g_q[i];
        5'd3:       inv_sel[i] = !g_q[i];
        5'd4:       inv_sel[i] = !g_q[i] && asm;
        5'd5:       inv_sel[i] = !g_q[i] && asm && vam;
        5'd6:       inv_sel[i] = (g_q[i] || asm) && vam;
        default:    inv_sel[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q     <= '0;
      fill_q  <= '0;
      inv_ack <= 1'b0;
      inv_err <= 1'b0;
    end else begin
      if (we) begin
        e_q[wr_idx] <= w_e;
      end else if (inv_acc) begin
        e_q <= e_q & ~inv_sel;
      end
      if (we && w_fill) fill_q <= fill_q + IW'(1);
      inv_ack <= inv_acc;
      inv_err <= inv_acc && (inv_op > 5'd6);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && we) begin
      ps4mb_q[wr_idx]   <= (w_ps == 6'd21);
      g_q[wr_idx]       <= w_g;
      vppn_q[wr_idx]    <= w_vppn;
      asid_q[wr_idx]    <= w_asid;
      ppn_q[0][wr_idx]  <= w_ppn0;
      ppn_q[1][wr_idx]  <= w_ppn1;
      plv_q[0][wr_idx]  <= w_plv0;
      plv_q[1][wr_idx]  <= w_plv1;
      mat_q[0][wr_idx]  <= w_mat0;
      mat_q[1][wr_idx]  <= w_mat1;
      d_q[wr_idx]       <= {w_d1, w_d0};
      v_q[wr_idx]       <= {w_v1, w_v0};
    end
  end

  assign fill_index = fill_q;

  // Search ports, handled as a two-element array.
  logic [1:0]  s_req, s_bit12;
  logic [18:0] s_vppn [2];
  logic [9:0]  s_asid [2];
  assign s_req   = {s1_req, s0_req};
  assign s_bit12 = {s1_va_bit12, s0_va_bit12};
  assign s_vppn[0] = s0_vppn;
  assign s_vppn[1] = s1_vppn;
  assign s_asid[0] = s0_asid;
  assign s_asid[1] = s1_asid;

  logic [TLBNUM-1:0] s_match [2];
  logic [1:0]        hit, odd;
  logic [IW-1:0]     hit_idx [2];
  logic [19:0]       sel_ppn [2];
  logic [5:0]        sel_ps  [2];
  logic [1:0]        sel_plv [2];
  logic [1:0]        sel_mat [2];
  logic [1:0]        sel_d, sel_v;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      hit[p]     = 1'b0;
      hit_idx[p] = '0;
      for (int i = 0; i < TLBNUM; i++) begin
        s_match[p][i] = e_q[i] && va_match(vppn_q[i], ps4mb_q[i], s_vppn[p]) &&
                        (g_q[i] || (asid_q[i] == s_asid[p]));
      end
      // Descending scan leaves the lowest matching index.
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if (s_match[p][i]) begin
          hit[p]     = 1'b1;
          hit_idx[p] = IW'(i);
        end
      end
      odd[p]     = ps4mb_q[hit_idx[p]] ? s_vppn[p][8] : s_bit12[p];
      sel_ppn[p] = '0;
      sel_ps[p]  = '0;
      sel_plv[p] = '0;
      sel_mat[p] = '0;
      sel_d[p]   = 1'b0;
      sel_v[p]   = 1'b0;
      if (hit[p]) begin
        sel_ppn[p] = ppn_q[odd[p]][hit_idx[p]];
        sel_ps[p]  = ps4mb_q[hit_idx[p]] ? 6'd21 : 6'd12;
        sel_plv[p] = plv_q[odd[p]][hit_idx[p]];
        sel_mat[p] = mat_q[odd[p]][hit_idx[p]];
        sel_d[p]   = d_q[hit_idx[p]][odd[p]];
        sel_v[p]   = v_q[hit_idx[p]][odd[p]];
      end
    end
  end

  logic [1:0]    sr_rvalid, sr_found, sr_d, sr_v;
  logic [IW-1:0] sr_index [2];
  logic [19:0]   sr_ppn   [2];
  logic [5:0]    sr_ps    [2];
  logic [1:0]    sr_plv   [2];
  logic [1:0]    sr_mat   [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_rvalid <= '0;
      sr_found  <= '0;
      sr_d      <= '0;
      sr_v      <= '0;
      for (int p = 0; p < 2; p++) begin
        sr_index[p] <= '0;
        sr_ppn[p]   <= '0;
        sr_ps[p]    <= '0;
        sr_plv[p]   <= '0;
        sr_mat[p]   <= '0;
      end
    end else begin
      sr_rvalid <= s_req;
      for (int p = 0; p < 2; p++) begin
        if (s_req[p]) begin
          sr_found[p] <= hit[p];
          sr_index[p] <= hit_idx[p];
          sr_ppn[p]   <= sel_ppn[p];
          sr_ps[p]    <= sel_ps[p];
          sr_plv[p]   <= sel_plv[p];
          sr_mat[p]   <= sel_mat[p];
          sr_d[p]     <= sel_d[p];
          sr_v[p]     <= sel_v[p];
        end
      end
    end
  end

  assign {s1_rvalid, s0_rvalid} = sr_rvalid;
  assign {s1_found, s0_found}   = sr_found;
  assign {s1_d, s0_d}           = sr_d;
  assign {s1_v, s0_v}           = sr_v;
  assign s0_index = sr_index[0];
  assign s1_index = sr_index[1];
  assign s0_ppn   = sr_ppn[0];
  assign s1_ppn   = sr_ppn[1];
  assign s0_ps    = sr_ps[0];
  assign s1_ps    = sr_ps[1];
  assign s0_plv   = sr_plv[0];
  assign s1_plv   = sr_plv[1];
  assign s0_mat   = sr_mat[0];
  assign s1_mat   = sr_mat[1];

`ifdef TLB_MULTIHIT_EN
  logic [1:0] multi, multi_q;
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      // Clearing the lowest set bit leaves something only if two or more bits were set.
      multi[p] = (s_match[p] & (s_match[p] - TLBNUM'(1))) != '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      multi_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (s_req[p]) multi_q[p] <= multi[p];
      end
    end
  end
  assign {s1_multihit, s0_multihit} = multi_q;
`endif

  // Read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_e      <= 1'b0;
      r_vppn   <= '0;
      r_ps     <= '0;
      r_asid   <= '0;
      r_g      <= 1'b0;
      r_ppn0   <= '0;
      r_plv0   <= '0;
      r_mat0   <= '0;
      r_d0     <= 1'b0;
      r_v0     <= 1'b0;
      r_ppn1   <= '0;
      r_plv1   <= '0;
      r_mat1   <= '0;
      r_d1     <= 1'b0;
      r_v1     <= 1'b0;
    end else begin
      r_rvalid <= r_req;
      if (r_req) begin
        r_e    <= e_q[r_index];
        r_vppn <= vppn_q[r_index];
        r_ps   <= ps4mb_q[r_index] ? 6'd21 : 6'd12;
        r_asid <= asid_q[r_index];
        r_g    <= g_q[r_index];
        r_ppn0 <= ppn_q[0][r_index];
        r_plv0 <= plv_q[0][r_index];
        r_mat0 <= mat_q[0][r_index];
        r_d0   <= d_q[r_index][0];
        r_v0   <= v_q[r_index][0];
        r_ppn1 <= ppn_q[1][r_index];
        r_plv1 <= plv_q[1][r_index];
        r_mat1 <= mat_q[1][r_index];
        r_d1   <= d_q[r_index][1];
        r_v1   <= v_q[r_index][1];
      end
    end
  end

endmodule

// File: tb/tb_tlb_pipe.sv
// Directed self-checking bench for tlb_pipe: search, read, write, fill wrap, INVTLB, conflicts.
module tb_tlb_pipe;
  localparam int unsigned TLBNUM = 16;
  localparam int unsigned IW = $clog2(TLBNUM);

  logic clk = 1'b0;
  logic reset;
  logic s0_req, s0_va_bit12, s1_req, s1_va_bit12;
  logic [18:0] s0_vppn, s1_vppn;
  logic [9:0]  s0_asid, s1_asid;
  logic s0_rvalid, s0_found, s0_d, s0_v, s1_rvalid, s1_found, s1_d, s1_v;
  logic [IW-1:0] s0_index, s1_index;
  logic [19:0] s0_ppn, s1_ppn;
  logic [5:0]  s0_ps, s1_ps;
  logic [1:0]  s0_plv, s0_mat, s1_plv, s1_mat;
`ifdef TLB_MULTIHIT_EN
  logic s0_multihit, s1_multihit;
`endif
  logic we, w_fill, w_e, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [IW-1:0] w_index, fill_index, r_index;
  logic [18:0] w_vppn, r_vppn, inv_vppn;
  logic [5:0]  w_ps, r_ps;
  logic [9:0]  w_asid, r_asid, inv_asid;
  logic [19:0] w_ppn0, w_ppn1, r_ppn0, r_ppn1;
  logic [1:0]  w_plv0, w_mat0, w_plv1, w_mat1, r_plv0, r_mat0, r_plv1, r_mat1;
  logic r_req, r_rvalid, r_e, r_g, r_d0, r_v0, r_d1, r_v1;
  logic inv_valid, inv_ack, inv_err;
  logic [4:0] inv_op;

  int checks = 0;
  int errors = 0;

  tlb_pipe #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .reset(reset),
    .s0_req(s0_req), .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
    .s0_rvalid(s0_rvalid), .s0_found(s0_found), .s0_index(s0_index), .s0_ppn(s0_ppn),
    .s0_ps(s0_ps), .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
`ifdef TLB_MULTIHIT_EN
    .s0_multihit(s0_multihit), .s1_multihit(s1_multihit),
`endif
    .s1_req(s1_req), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
    .s1_rvalid(s1_rvalid), .s1_found(s1_found), .s1_index(s1_index), .s1_ppn(s1_ppn),
    .s1_ps(s1_ps), .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_fill(w_fill), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
    .w_asid(w_asid), .w_g(w_g), .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0),
    .w_d0(w_d0), .w_v0(w_v0), .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1),
    .w_d1(w_d1), .w_v1(w_v1), .fill_index(fill_index),
    .r_req(r_req), .r_index(r_index), .r_rvalid(r_rvalid), .r_e(r_e), .r_vppn(r_vppn),
    .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g), .r_ppn0(r_ppn0), .r_plv0(r_plv0),
    .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0), .r_ppn1(r_ppn1), .r_plv1(r_plv1),
    .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1),
    .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .inv_ack(inv_ack), .inv_err(inv_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle write; leaves we low afterwards.
  task automatic wr(input logic fill, input logic [IW-1:0] idx, input logic [18:0] vppn,
                    input logic [5:0] ps, input logic [9:0] asid, input logic g,
                    input logic [19:0] p0, input logic [19:0] p1);
    we = 1'b1; w_fill = fill; w_index = idx; w_e = 1'b1; w_vppn = vppn; w_ps = ps;
    w_asid = asid; w_g = g; w_ppn0 = p0; w_ppn1 = p1;
    tick();
    we = 1'b0;
  endtask

  task automatic search2(input logic [18:0] v0, input logic b0, input logic [9:0] a0,
                         input logic [18:0] v1, input logic b1, input logic [9:0] a1);
    s0_req = 1'b1; s0_vppn = v0; s0_va_bit12 = b0; s0_asid = a0;
    s1_req = 1'b1; s1_vppn = v1; s1_va_bit12 = b1; s1_asid = a1;
    tick();
    s0_req = 1'b0; s1_req = 1'b0;
  endtask

  task automatic invtlb(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn);
    inv_valid = 1'b1; inv_op = op; inv_asid = asid; inv_vppn = vppn;
    tick();
    inv_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    s0_req = 0; s0_vppn = 0; s0_va_bit12 = 0; s0_asid = 0;
    s1_req = 0; s1_vppn = 0; s1_va_bit12 = 0; s1_asid = 0;
    we = 0; w_fill = 0; w_index = 0; w_e = 0; w_vppn = 0; w_ps = 0; w_asid = 0; w_g = 0;
    w_ppn0 = 0; w_ppn1 = 0; w_plv0 = 2'd1; w_mat0 = 2'd1; w_d0 = 1'b0; w_v0 = 1'b1;
    w_plv1 = 2'd3; w_mat1 = 2'd2; w_d1 = 1'b1; w_v1 = 1'b1;
    r_req = 0; r_index = 0; inv_valid = 0; inv_op = 0; inv_asid = 0; inv_vppn = 0;

    // Reset state
    tick(); tick();
    check("rst_s0_rvalid", s0_rvalid, 0);
    check("rst_s1_found", s1_found, 0);
    check("rst_fill_index", fill_index, 0);
    check("rst_inv_ack", inv_ack, 0);
    check("rst_r_rvalid", r_rvalid, 0);
    reset = 1'b0;

    // Search on an empty TLB
    s0_req = 1'b1; s0_vppn = 19'h00010; s0_va_bit12 = 0; s0_asid = 0;
    tick();
    s0_req = 1'b0;
    check("empty_rvalid", s0_rvalid, 1);
    check("empty_found", s0_found, 0);
    check("empty_index", s0_index, 0);
    check("empty_ppn", s0_ppn, 0);
    tick();
    check("rvalid_pulse", s0_rvalid, 0);

    // 4 KB pair at index 5
    wr(1'b0, 4'd5, 19'h00123, 6'd12, 10'd3, 1'b0, 20'hAAAAA, 20'hBBBBB);
    search2(19'h00123, 1'b0, 10'd3, 19'h00123, 1'b1, 10'd3);
    check("4k_s1_found", s1_found, 1);
    check("4k_s1_index", s1_index, 5);
    check("4k_s1_ppn", s1_ppn, 20'hBBBBB);
    check("4k_s1_ps", s1_ps, 12);
    check("4k_s1_plv", s1_plv, 3);
    check("4k_s1_d", s1_d, 1);
    check("4k_s0_ppn", s0_ppn, 20'hAAAAA);
    check("4k_s0_plv", s0_plv, 1);
    check("4k_s0_d", s0_d, 0);
    search2(19'h00123, 1'b1, 10'd4, 19'h00123, 1'b1, 10'd4);
    check("4k_asid_miss", s1_found, 0);
    check("4k_asid_miss_ppn", s1_ppn, 0);

    // 4 MB global page at index 2
    wr(1'b0, 4'd2, 19'h40000, 6'd21, 10'd0, 1'b1, 20'h11111, 20'h22222);
    search2(19'h401FF, 1'b0, 10'd7, 19'h40000, 1'b1, 10'd9);
    check("4m_s0_found", s0_found, 1);
    check("4m_s0_index", s0_index, 2);
    check("4m_s0_ppn_odd", s0_ppn, 20'h22222);
    check("4m_s0_ps", s0_ps, 21);
    check("4m_s1_ppn_even", s1_ppn, 20'h11111);
    r_req = 1'b1; r_index = 4'd2;
    tick();
    r_req = 1'b0;
    check("rd_rvalid", r_rvalid, 1);
    check("rd_ps", r_ps, 21);
    check("rd_vppn", r_vppn, 19'h40000);
    check("rd_g_e", {r_g, r_e}, 2'b11);

    // TLBFILL wrap: TLBNUM+1 fills, last duplicates entry 1's tag into entry 0
    for (int i = 0; i <= TLBNUM; i++) begin
      check($sformatf("fill_idx_%0d", i), fill_index, i % TLBNUM);
      wr(1'b1, 4'd9, (i == TLBNUM) ? 19'h60001 : (19'h60000 | 19'(i)), 6'd12, 10'd0, 1'b1,
         20'h30000 + 20'(i), 20'h0);
    end
    check("fill_after_wrap", fill_index, 1);
    search2(19'h60001, 1'b0, 10'd0, 19'h60005, 1'b0, 10'd0);
    check("dup_found", s0_found, 1);
    check("dup_lowest", s0_index, 0);
    check("dup_ppn", s0_ppn, 20'h30010);
    check("fill5_index", s1_index, 5);
`ifdef TLB_MULTIHIT_EN
    check("dup_multihit", s0_multihit, 1);
    check("single_multihit", s1_multihit, 0);
`endif

    // INVTLB op 5 vs op 6: A at 3 (g=0, asid=3), B at 4 (g=1, asid=9)
    wr(1'b0, 4'd3, 19'h07777, 6'd12, 10'd3, 1'b0, 20'h0000A, 20'h0);
    wr(1'b0, 4'd4, 19'h07777, 6'd12, 10'd9, 1'b1, 20'h0000B, 20'h0);
    invtlb(5'd5, 10'd3, 19'h07777);
    check("op5_ack", inv_ack, 1);
    check("op5_err", inv_err, 0);
    search2(19'h07777, 1'b0, 10'd3, 19'h07777, 1'b0, 10'd9);
    check("op5_ack_pulse", inv_ack, 0);
    check("op5_a_gone", s0_index, 4);
    check("op5_b_kept", s1_found, 1);
    wr(1'b0, 4'd3, 19'h07777, 6'd12, 10'd3, 1'b0, 20'h0000A, 20'h0);
    invtlb(5'd6, 10'd1, 19'h07777);
    search2(19'h07777, 1'b0, 10'd3, 19'h07777, 1'b0, 10'd9);
    check("op6_a_kept", s0_index, 3);
    check("op6_a_ppn", s0_ppn, 20'h0000A);
    check("op6_b_gone", s1_found, 0);
    invtlb(5'd9, 10'd3, 19'h07777);
    check("op9_err", inv_err, 1);
    search2(19'h07777, 1'b0, 10'd3, 19'h07777, 1'b0, 10'd3);
    check("op9_err_pulse", inv_err, 0);
    check("op9_no_change", s0_found, 1);

    // Write and INVTLB op 0 together: write wins, invalidate waits a cycle
    inv_valid = 1'b1; inv_op = 5'd0;
    wr(1'b0, 4'd7, 19'h01234, 6'd12, 10'd5, 1'b0, 20'h77777, 20'h0);
    check("conf_no_ack", inv_ack, 0);
    s0_req = 1'b1; s0_vppn = 19'h01234; s0_va_bit12 = 0; s0_asid = 10'd5;
    tick();
    inv_valid = 1'b0; s0_req = 1'b0;
    check("conf_ack", inv_ack, 1);
    check("conf_pre_update", s0_index, 7);
    check("conf_pre_ppn", s0_ppn, 20'h77777);
    search2(19'h01234, 1'b0, 10'd5, 19'h60001, 1'b0, 10'd0);
    check("conf_cleared", s0_found, 0);
    check("conf_all_cleared", s1_found, 0);

    // Reset overrides pending requests
    reset = 1'b1; s0_req = 1'b1; r_req = 1'b1;
    tick();
    reset = 1'b0; s0_req = 1'b0; r_req = 1'b0;
    check("midrst_rvalid", s0_rvalid, 0);
    check("midrst_r_rvalid", r_rvalid, 0);
    check("midrst_fill", fill_index, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
